// File: rtl/vec_issue_sb_if.sv
// Instruction-in, micro-op-out and writeback signals of the vector issue scoreboard.
// The master drives instructions and writebacks; the slave is the issue block.
interface vec_issue_sb_if #(
  parameter int unsigned VECTOR_REGISTERS = 32,
  parameter int unsigned VECTOR_LANES     = 8,
  parameter int unsigned MAXVL            = 64
);
  localparam int unsigned RW = $clog2(VECTOR_REGISTERS);
  localparam int unsigned VW = $clog2(MAXVL) + 1;

  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [RW-1:0]           in_dst_i;
  logic [RW-1:0]           in_src1_i;
  logic [RW-1:0]           in_src2_i;
  logic [VW-1:0]           in_vl_i;

  logic                    uop_valid_o;
  logic                    uop_ready_i;
  logic [RW-1:0]           uop_dst_o;
  logic [RW-1:0]           uop_src1_o;
  logic [RW-1:0]           uop_src2_o;
  logic [VECTOR_LANES-1:0] uop_lane_en_o;
  logic                    uop_head_o;
  logic                    uop_end_o;

  logic [VECTOR_LANES-1:0] wb_en_i;
  logic [RW-1:0]           wb_addr_i;

  modport master (
    output in_valid_i, in_dst_i, in_src1_i, in_src2_i, in_vl_i,
    output uop_ready_i, wb_en_i, wb_addr_i,
    input  in_ready_o, uop_valid_o, uop_dst_o, uop_src1_o, uop_src2_o,
    input  uop_lane_en_o, uop_head_o, uop_end_o
  );

  modport slave (
    input  in_valid_i, in_dst_i, in_src1_i, in_src2_i, in_vl_i,
    input  uop_ready_i, wb_en_i, wb_addr_i,
    output in_ready_o, uop_valid_o, uop_dst_o, uop_src1_o, uop_src2_o,
    output uop_lane_en_o, uop_head_o, uop_end_o
  );
endinterface

// File: rtl/vec_issue_sb.sv
// Vector issue stage: instruction FIFO, expansion into per-lane-group micro-ops,
// and a per-register/per-lane pending scoreboard blocking RAW and WAW hazards.
module vec_issue_sb #(
  parameter int unsigned VECTOR_REGISTERS = 32,
  parameter int unsigned VECTOR_LANES     = 8,
  parameter int unsigned QUEUE_DEPTH      = 4,
  parameter int unsigned MAXVL            = 64
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           flush_i,
  vec_issue_sb_if.slave  bus,
  output logic           idle_o
);
  localparam int unsigned RW   = $clog2(VECTOR_REGISTERS);
  localparam int unsigned VW   = $clog2(MAXVL) + 1;
  localparam int unsigned LB   = $clog2(VECTOR_LANES);
  localparam int unsigned PW   = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned NMAX = MAXVL / VECTOR_LANES;
  localparam int unsigned KW   = $clog2(NMAX) + 1;

  typedef struct packed {
    logic [RW-1:0] dst;
    logic [RW-1:0] src1;
    logic [RW-1:0] src2;
    logic [VW-1:0] vl;
  } entry_t;

  typedef enum logic {S_IDLE, S_EXPAND} state_t;

  entry_t                  r_q [QUEUE_DEPTH];
  logic [PW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]           r_cnt;
  state_t                  r_state;
  logic [KW-1:0]           r_k;
  logic [VECTOR_LANES-1:0] r_pend [VECTOR_REGISTERS];
  logic                    r_in_ready, r_idle;
  logic                    r_uop_valid, r_uop_head, r_uop_end;
  logic [RW-1:0]           r_uop_dst, r_uop_src1, r_uop_src2;
  logic [VECTOR_LANES-1:0] r_uop_lane_en;

  entry_t                  w_head, w_in_entry;
  logic [VW-1:0]           w_rem;
  logic [VECTOR_LANES-1:0] w_en;
  logic [RW-1:0]           w_dst, w_src1, w_src2;
  logic                    w_last, w_zero, w_hazard, w_active;
  logic                    w_load, w_pop, w_push, w_valid_nxt, w_idle_nxt, w_any_pend;
  logic [CW-1:0]           w_cnt_nxt;
  state_t                  w_state_nxt;
  logic [VECTOR_LANES-1:0] w_pend_nxt [VECTOR_REGISTERS];

  // Current micro-op of the head entry, hazard check, and next-state values
  always_comb begin
    w_in_entry.dst  = bus.in_dst_i;
    w_in_entry.src1 = bus.in_src1_i;
    w_in_entry.src2 = bus.in_src2_i;
    w_in_entry.vl   = (bus.in_vl_i > VW'(MAXVL)) ? VW'(MAXVL) : bus.in_vl_i;

    w_active = (r_state == S_EXPAND);
    w_head   = r_q[r_rd_ptr];
    w_rem    = w_head.vl - (VW'(r_k) << LB);
    for (int l = 0; l < int'(VECTOR_LANES); l++) begin
      w_en[l] = (VW'(l) < w_rem);
    end
    w_last   = (w_rem <= VW'(VECTOR_LANES));
    w_zero   = (w_head.vl == '0);
    w_dst    = w_head.dst  + RW'(r_k);
    w_src1   = w_head.src1 + RW'(r_k);
    w_src2   = w_head.src2 + RW'(r_k);
    w_hazard = |((r_pend[w_dst] | r_pend[w_src1] | r_pend[w_src2]) & w_en);

    w_load = w_active && !w_zero && !w_hazard && (!r_uop_valid || bus.uop_ready_i);
    w_pop  = w_active && (w_zero || (w_load && w_last));
    w_push = bus.in_valid_i && r_in_ready;

    w_cnt_nxt   = r_cnt + CW'(w_push) - CW'(w_pop);
    w_valid_nxt = w_load || (r_uop_valid && !bus.uop_ready_i);

    // Writeback clears first so a same-cycle issue set wins
    w_pend_nxt = r_pend;
    w_pend_nxt[bus.wb_addr_i] = w_pend_nxt[bus.wb_addr_i] & ~bus.wb_en_i;
    if (w_load) begin
      w_pend_nxt[w_dst] = w_pend_nxt[w_dst] | w_en;
    end

    if (flush_i) begin
      w_cnt_nxt   = '0;
      w_valid_nxt = 1'b0;
      for (int r = 0; r < int'(VECTOR_REGISTERS); r++) begin
        w_pend_nxt[r] = '0;
      end
    end

    w_any_pend = 1'b0;
    for (int r = 0; r < int'(VECTOR_REGISTERS); r++) begin
      w_any_pend = w_any_pend | (|w_pend_nxt[r]);
    end
    w_idle_nxt  = (w_cnt_nxt == '0) && !w_valid_nxt && !w_any_pend;
    w_state_nxt = (w_cnt_nxt != '0) ? S_EXPAND : S_IDLE;
  end

  // Queue payload storage needs no reset; occupancy tracking qualifies it
  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) begin
      r_q[r_wr_ptr] <= w_in_entry;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_cnt         <= '0;
      r_k           <= '0;
      r_in_ready    <= 1'b1;
      r_idle        <= 1'b1;
      r_uop_valid   <= 1'b0;
      r_uop_head    <= 1'b0;
      r_uop_end     <= 1'b0;
      r_uop_dst     <= '0;
      r_uop_src1    <= '0;
      r_uop_src2    <= '0;
      r_uop_lane_en <= '0;
      for (int r = 0; r < int'(VECTOR_REGISTERS); r++) begin
        r_pend[r] <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend      <= w_pend_nxt;
      r_uop_valid <= w_valid_nxt;
      r_in_ready  <= (w_cnt_nxt != CW'(QUEUE_DEPTH));
      r_idle      <= w_idle_nxt;
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_k      <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        if (w_load) begin
          r_uop_dst     <= w_dst;
          r_uop_src1    <= w_src1;
          r_uop_src2    <= w_src2;
          r_uop_lane_en <= w_en;
          r_uop_head    <= (r_k == '0);
          r_uop_end     <= w_last;
          r_k           <= w_last ? '0 : r_k + KW'(1);
        end
      end
    end
  end

  assign bus.in_ready_o    = r_in_ready;
  assign bus.uop_valid_o   = r_uop_valid;
  assign bus.uop_dst_o     = r_uop_dst;
  assign bus.uop_src1_o    = r_uop_src1;
  assign bus.uop_src2_o    = r_uop_src2;
  assign bus.uop_lane_en_o = r_uop_lane_en;
  assign bus.uop_head_o    = r_uop_head;
  assign bus.uop_end_o     = r_uop_end;
  assign idle_o            = r_idle;
endmodule
